// File: rtl/id_ctrl_pipe.sv
// id_ctrl_pipe: MIPS-I ID-stage decoder with a registered EX control word,
// load-use and HI/LO interlocks, and a HI/LO busy down-counter.
// Optional feature macro: CTRL_DIV_EN. When it is defined, DIV/DIVU decode to
// alu_op 13 and load DIV_LAT. When it is undefined, DIV/DIVU decode as illegal.
// ctrl_e layout: [14] reg_we, [13:12] reg_dst, [11:8] alu_op, [7] alu_src_imm,
//   [6:5] ext_op, [4] mem_we, [3] mem_to_reg, [2:1] jump, [0] link.
module id_ctrl_pipe #(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr_d,
   input  logic        valid_d,
   input  logic        flush,
   output logic [14:0] ctrl_e,
   output logic        valid_e,
   output logic        illegal_e,
   output logic        stall_d,
   output logic        hilo_busy
);

   localparam logic [5:0] MUL_LOAD = 6'(MUL_LAT);
   localparam logic [5:0] DIV_LOAD = 6'(DIV_LAT);

   localparam logic [3:0] ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2,
                          ALU_AND = 4'd3, ALU_OR = 4'd4, ALU_XOR = 4'd5,
                          ALU_NOR = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8,
                          ALU_SRA = 4'd9, ALU_SLT = 4'd10, ALU_SLTU = 4'd11,
                          ALU_MUL = 4'd12, ALU_DIV = 4'd13, ALU_HIW = 4'd14,
                          ALU_HIR = 4'd15;

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [14:0] dec_ctrl;
   logic        dec_ill;
   logic        reads_rt;
   logic        is_hilo;
   logic        is_mul;
   logic        is_div;
   logic        load_use;
   logic        issue;
   logic [4:0]  ex_rt;
   logic        ex_m2r;
   logic [5:0]  busy_cnt;
   logic        unused_fields;

   assign op    = instr_d[31:26];
   assign rs    = instr_d[25:21];
   assign rt    = instr_d[20:16];
   assign funct = instr_d[5:0];
   // rd, shamt and the immediate are consumed downstream, not by this block
   assign unused_fields = ^instr_d[15:6];

   function automatic logic [14:0] cw(
      input logic       we,
      input logic [1:0] dst,
      input logic [3:0] alu,
      input logic       imm,
      input logic [1:0] ext,
      input logic       mwe,
      input logic       m2r,
      input logic [1:0] jmp,
      input logic       lnk
   );
      return {we, dst, alu, imm, ext, mwe, m2r, jmp, lnk};
   endfunction

   // Instruction decode; anything unlisted is illegal and yields an all-zero word
   always_comb begin
      dec_ctrl = '0;
      dec_ill  = 1'b0;
      reads_rt = 1'b0;
      is_hilo  = 1'b0;
      is_mul   = 1'b0;
      is_div   = 1'b0;
      case (op)
         6'h00: begin
            case (funct)
               6'h00, 6'h04: begin dec_ctrl = cw(1, 2'd1, ALU_SLL, 0, 2'd0, 0, 0, 2'd0, 0); reads_rt = 1'b1; end
               6'h02, 6'h06: begin dec_ctrl = cw(1, 2'd1, ALU_SRL, 0, 2'd0, 0, 0, 2'd0, 0); reads_rt = 1'b1; end
               6'h03, 6'h07: begin dec_ctrl = cw(1, 2'd1, ALU_SRA, 0, 2'd0, 0, 0, 2'd0, 0); reads_rt = 1'b1; end
               6'h08: dec_ctrl = cw(0, 2'd0, ALU_NOP, 0, 2'd0, 0, 0, 2'd3, 0);
               6'h09: dec_ctrl = cw(1, 2'd1, ALU_NOP, 0, 2'd0, 0, 0, 2'd3, 1);
               6'h10, 6'h12: begin dec_ctrl = cw(1, 2'd1, ALU_HIR, 0, 2'd0, 0, 0, 2'd0, 0); is_hilo = 1'b1; end
               6'h11, 6'h13: begin dec_ctrl = cw(0, 2'd0, ALU_HIW, 0, 2'd0, 0, 0, 2'd0, 0); is_hilo = 1'b1; end
               6'h18, 6'h19: begin
                  dec_ctrl = cw(0, 2'd0, ALU_MUL, 0, 2'd0, 0, 0, 2'd0, 0);
                  is_hilo  = 1'b1;
                  is_mul   = 1'b1;
                  reads_rt = 1'b1;
               end
`ifdef CTRL_DIV_EN
               6'h1A, 6'h1B: begin
                  dec_ctrl = cw(0, 2'd0, ALU_DIV, 0, 2'd0, 0, 0, 2'd0, 0);
                  is_hilo  = 1'b1;
                  is_div   = 1'b1;
                  reads_rt = 1'b1;
               end
`else
               6'h1A, 6'h1B: dec_ill = 1'b1;
`endif
               6'h20, 6'h21: begin dec_ctrl = cw(1, 2'd1, ALU_ADD,  0, 2'd0, 0, 0, 2'd0, 0); reads_rt = 1'b1; end
               6'h22, 6'h23: begin dec_ctrl = cw(1, 2'd1, ALU_SUB,  0, 2'd0, 0, 0, 2'd0, 0); reads_rt = 1'b1; end
               6'h24: begin dec_ctrl = cw(1, 2'd1, ALU_AND,  0, 2'd0, 0, 0, 2'd0, 0); reads_rt = 1'b1; end
               6'h25: begin dec_ctrl = cw(1, 2'd1, ALU_OR,   0, 2'd0, 0, 0, 2'd0, 0); reads_rt = 1'b1; end
               6'h26: begin dec_ctrl = cw(1, 2'd1, ALU_XOR,  0, 2'd0, 0, 0, 2'd0, 0); reads_rt = 1'b1; end
               6'h27: begin dec_ctrl = cw(1, 2'd1, ALU_NOR,  0, 2'd0, 0, 0, 2'd0, 0); reads_rt = 1'b1; end
               6'h2A: begin dec_ctrl = cw(1, 2'd1, ALU_SLT,  0, 2'd0, 0, 0, 2'd0, 0); reads_rt = 1'b1; end
               6'h2B: begin dec_ctrl = cw(1, 2'd1, ALU_SLTU, 0, 2'd0, 0, 0, 2'd0, 0); reads_rt = 1'b1; end
               default: dec_ill = 1'b1;
            endcase
         end
         6'h02: dec_ctrl = cw(0, 2'd0, ALU_NOP, 0, 2'd0, 0, 0, 2'd2, 0);
         6'h03: dec_ctrl = cw(1, 2'd2, ALU_NOP, 0, 2'd0, 0, 0, 2'd2, 1);
         6'h04, 6'h05: begin dec_ctrl = cw(0, 2'd0, ALU_SUB, 0, 2'd0, 0, 0, 2'd1, 0); reads_rt = 1'b1; end
         6'h06, 6'h07: dec_ctrl = cw(0, 2'd0, ALU_SUB, 0, 2'd0, 0, 0, 2'd1, 0);
         6'h08, 6'h09: dec_ctrl = cw(1, 2'd0, ALU_ADD,  1, 2'd0, 0, 0, 2'd0, 0);
         6'h0A: dec_ctrl = cw(1, 2'd0, ALU_SLT,  1, 2'd0, 0, 0, 2'd0, 0);
         6'h0B: dec_ctrl = cw(1, 2'd0, ALU_SLTU, 1, 2'd0, 0, 0, 2'd0, 0);
         6'h0C: dec_ctrl = cw(1, 2'd0, ALU_AND,  1, 2'd1, 0, 0, 2'd0, 0);
         6'h0D: dec_ctrl = cw(1, 2'd0, ALU_OR,   1, 2'd1, 0, 0, 2'd0, 0);
         6'h0E: dec_ctrl = cw(1, 2'd0, ALU_XOR,  1, 2'd1, 0, 0, 2'd0, 0);
         6'h0F: dec_ctrl = cw(1, 2'd0, ALU_ADD,  1, 2'd2, 0, 0, 2'd0, 0);
         6'h20, 6'h23, 6'h24: dec_ctrl = cw(1, 2'd0, ALU_ADD, 1, 2'd0, 0, 1, 2'd0, 0);
         6'h28, 6'h2B: begin dec_ctrl = cw(0, 2'd0, ALU_ADD, 1, 2'd0, 1, 0, 2'd0, 0); reads_rt = 1'b1; end
         default: dec_ill = 1'b1;
      endcase
   end

   // Interlocks: load-use against the EX load, HI/LO ops against the busy unit
   always_comb begin
      load_use = ex_m2r && (ex_rt != 5'd0) &&
                 ((ex_rt == rs) || (reads_rt && (ex_rt == rt)));
      stall_d  = valid_d && !flush && (load_use || (is_hilo && hilo_busy));
      issue    = valid_d && !flush && !stall_d;
   end

   // EX control register; stalls, flushes and empty slots become bubbles
   always_ff @(posedge clk) begin
      if (reset || !issue) begin
         ctrl_e    <= '0;
         valid_e   <= 1'b0;
         illegal_e <= 1'b0;
         ex_rt     <= '0;
         ex_m2r    <= 1'b0;
      end else begin
         ctrl_e    <= dec_ctrl;
         valid_e   <= 1'b1;
         illegal_e <= dec_ill;
         ex_rt     <= rt;
         ex_m2r    <= dec_ctrl[3];
      end
   end

   // HI/LO busy down-counter: load on multiply/divide issue, else count to zero
   always_ff @(posedge clk) begin
      if (reset)
         busy_cnt <= '0;
      else if (issue && (is_mul || is_div))
         busy_cnt <= is_div ? DIV_LOAD : MUL_LOAD;
      else if (busy_cnt != 6'd0)
         busy_cnt <= busy_cnt - 6'd1;
   end

   assign hilo_busy = (busy_cnt != 6'd0);

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Directed bench for id_ctrl_pipe (default build, CTRL_DIV_EN undefined, MUL_LAT=4).
module tb_id_ctrl_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr_d;
   logic        valid_d;
   logic        flush;
   logic [14:0] ctrl_e;
   logic        valid_e;
   logic        illegal_e;
   logic        stall_d;
   logic        hilo_busy;

   int nchk = 0;
   int nerr = 0;

   id_ctrl_pipe #(.MUL_LAT(4), .DIV_LAT(32)) dut (
      .clk(clk), .reset(reset), .instr_d(instr_d), .valid_d(valid_d),
      .flush(flush), .ctrl_e(ctrl_e), .valid_e(valid_e),
      .illegal_e(illegal_e), .stall_d(stall_d), .hilo_busy(hilo_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] i, input logic v, input logic f);
      instr_d = i;
      valid_d = v;
      flush   = f;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_issue(input string tag, input logic [14:0] c, input logic v, input logic il);
      chk({tag, "_ctrl"}, 32'(ctrl_e), 32'(c));
      chk({tag, "_valid"}, 32'(valid_e), 32'(v));
      chk({tag, "_illegal"}, 32'(illegal_e), 32'(il));
   endtask

   localparam logic [31:0] LW5  = 32'h8C250000;
   localparam logic [31:0] USE_RS = 32'h00A23021;
   localparam logic [31:0] USE_RT = 32'h00453021;
   localparam logic [31:0] MULT = 32'h00220018;
   localparam logic [31:0] MFHI = 32'h00002010;

   logic [31:0] tbl_i [9] = '{32'h00221821, 32'h0C000010, 32'h10220003,
                              32'h342300FF, 32'hAC250004, 32'h3C031234,
                              32'h00021903, 32'h03E00008, 32'h00200013};
   logic [14:0] tbl_c [9] = '{15'h5100, 15'h6005, 15'h0202, 15'h44A0,
                              15'h0190, 15'h41C0, 15'h5900, 15'h0006, 15'h0E00};

   initial begin
      reset = 1'b1;
      drive(32'h0, 1'b0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      chk_issue("reset", 15'h0, 1'b0, 1'b0);
      chk("reset_busy", 32'(hilo_busy), 32'd0);
      chk("reset_stall", 32'(stall_d), 32'd0);

      // back-to-back decode of non-load instructions
      for (int k = 0; k < 9; k++) begin
         drive(tbl_i[k], 1'b1, 1'b0);
         chk($sformatf("dec%0d_stall", k), 32'(stall_d), 32'd0);
         tick();
         chk_issue($sformatf("dec%0d", k), tbl_c[k], 1'b1, 1'b0);
      end

      // load-use on rs: one stall, one bubble, then issue
      drive(LW5, 1'b1, 1'b0);
      tick();
      chk_issue("lw", 15'h4188, 1'b1, 1'b0);
      drive(USE_RS, 1'b1, 1'b0);
      chk("lu_rs_stall", 32'(stall_d), 32'd1);
      tick();
      chk_issue("lu_rs_bubble", 15'h0, 1'b0, 1'b0);
      chk("lu_rs_stall2", 32'(stall_d), 32'd0);
      tick();
      chk_issue("lu_rs_issue", 15'h5100, 1'b1, 1'b0);

      // load-use on rt
      drive(LW5, 1'b1, 1'b0);
      tick();
      drive(USE_RT, 1'b1, 1'b0);
      chk("lu_rt_stall", 32'(stall_d), 32'd1);
      tick();
      chk_issue("lu_rt_bubble", 15'h0, 1'b0, 1'b0);

      // rt of ADDIU is a destination, not a source: no stall
      drive(LW5, 1'b1, 1'b0);
      tick();
      drive(32'h24250001, 1'b1, 1'b0);
      chk("addiu_stall", 32'(stall_d), 32'd0);
      tick();
      chk_issue("addiu", 15'h4180, 1'b1, 1'b0);

      // load into r0 never interlocks
      drive(32'h8C200000, 1'b1, 1'b0);
      tick();
      drive(32'h00023021, 1'b1, 1'b0);
      chk("r0_stall", 32'(stall_d), 32'd0);
      tick();
      chk_issue("r0_use", 15'h5100, 1'b1, 1'b0);

      // flush beats a load-use stall
      drive(LW5, 1'b1, 1'b0);
      tick();
      drive(USE_RS, 1'b1, 1'b1);
      chk("flush_stall", 32'(stall_d), 32'd0);
      tick();
      chk_issue("flush_bubble", 15'h0, 1'b0, 1'b0);

      // empty slot behind a load
      drive(LW5, 1'b1, 1'b0);
      tick();
      drive(USE_RS, 1'b0, 1'b0);
      chk("novalid_stall", 32'(stall_d), 32'd0);
      tick();
      chk_issue("novalid_bubble", 15'h0, 1'b0, 1'b0);

      // MULT then MFHI: busy exactly 4 cycles, MFHI held for all 4
      drive(MULT, 1'b1, 1'b0);
      chk("mult_busy_pre", 32'(hilo_busy), 32'd0);
      chk("mult_stall", 32'(stall_d), 32'd0);
      tick();
      chk_issue("mult", 15'h0C00, 1'b1, 1'b0);
      drive(MFHI, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("mfhi_busy%0d", k), 32'(hilo_busy), 32'd1);
         chk($sformatf("mfhi_stall%0d", k), 32'(stall_d), 32'd1);
         tick();
         chk($sformatf("mfhi_bubble%0d", k), 32'(valid_e), 32'd0);
      end
      chk("mfhi_busy_done", 32'(hilo_busy), 32'd0);
      chk("mfhi_stall_done", 32'(stall_d), 32'd0);
      tick();
      chk_issue("mfhi", 15'h5F00, 1'b1, 1'b0);

      // DIV is illegal in this build and leaves the counter alone
      drive(32'h0022001A, 1'b1, 1'b0);
      tick();
      chk_issue("div", 15'h0, 1'b1, 1'b1);
      chk("div_busy", 32'(hilo_busy), 32'd0);
      drive(32'h0, 1'b0, 1'b0);
      tick();
      chk("div_busy2", 32'(hilo_busy), 32'd0);

      // unknown opcode
      drive(32'hFC000000, 1'b1, 1'b0);
      tick();
      chk_issue("badop", 15'h0, 1'b1, 1'b1);

      // reset aborts a countdown
      drive(MULT, 1'b1, 1'b0);
      tick();
      chk("rst_busy_pre", 32'(hilo_busy), 32'd1);
      reset = 1'b1;
      drive(32'h0, 1'b0, 1'b0);
      tick();
      reset = 1'b0;
      chk("rst_busy", 32'(hilo_busy), 32'd0);
      chk_issue("rst_mid", 15'h0, 1'b0, 1'b0);
      drive(MFHI, 1'b1, 1'b0);
      chk("rst_stall", 32'(stall_d), 32'd0);
      tick();
      chk_issue("rst_mfhi", 15'h5F00, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
